// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: 3x3 sliding-window multiply-accumulate behind the 3-row line buffer.
// One column in per valid cycle, one rounded/shifted/saturated pixel out per complete window.
// Five pipeline stages: window, products, row sums, total, round/shift/saturate.
// Build option: define CONV_RELU_EN to clamp negative results to zero in the final stage.
module conv3x3_window_mac #(
  parameter int WIDTH   = 16,
  parameter int COEF_W  = 8,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 0,
  parameter int COL_NUM = 480,
  parameter int ROW_NUM = 272
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      row_top,
  input  logic [WIDTH-1:0]      row_mid,
  input  logic [WIDTH-1:0]      row_bot,
  input  logic                  col_valid,
  input  logic                  coef_load,
  input  logic [9*COEF_W-1:0]   coef_bus,
  output logic [OUT_W-1:0]      dout,
  output logic                  dout_valid,
  output logic                  frame_done
);

  localparam int PROD_W = WIDTH + COEF_W;
  localparam int SUM_W  = WIDTH + COEF_W + 4;
  localparam int EXT_W  = SUM_W + 1;
  localparam int COL_W  = ($clog2(COL_NUM) > 2) ? $clog2(COL_NUM) : 2;
  localparam int ROW_W  = ((ROW_NUM - 3) > 1) ? $clog2(ROW_NUM - 3) : 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COL_NUM - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROW_NUM - 4);

  localparam logic signed [EXT_W-1:0] RND     = (SHIFT > 0) ? (EXT_W'(1) << RND_SH) : '0;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(longint'(1) << (OUT_W - 1)));

  logic [COL_W-1:0]         r_col_cnt;
  logic [ROW_W-1:0]         r_row_cnt;
  logic signed [WIDTH-1:0]  r_win  [3][3];
  logic signed [COEF_W-1:0] r_coef [9];
  logic signed [PROD_W-1:0] r_prod [9];
  logic signed [SUM_W-1:0]  r_rsum [3];
  logic signed [SUM_W-1:0]  r_sum;
  logic                     r_v1, r_v2, r_v3, r_v4;
  logic                     r_l1, r_l2, r_l3, r_l4;

  logic                     w_last_col;
  logic                     w_last_row;
  logic signed [EXT_W-1:0]  w_rnd;
  logic signed [EXT_W-1:0]  w_shf;
  logic signed [OUT_W-1:0]  w_sat;
  logic signed [OUT_W-1:0]  w_res;

  assign w_last_col = (r_col_cnt == COL_LAST);
  assign w_last_row = (r_row_cnt == ROW_LAST);

  // Column/row position of the incoming column; row advances on column wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (col_valid) begin
      if (w_last_col) begin
        r_col_cnt <= '0;
        r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
      end else begin
        r_col_cnt <= r_col_cnt + 1'b1;
      end
    end
  end

  // S1: window shift registers, newest column enters at c=2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          r_win[r][c] <= '0;
    end else if (col_valid) begin
      for (int unsigned r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= row_top;
      r_win[1][2] <= row_mid;
      r_win[2][2] <= row_bot;
    end
  end

  // Coefficient bank; a load lands on the same edge as a window, so that window meets it in S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 9; k++)
        r_coef[k] <= '0;
    end else if (coef_load) begin
      for (int unsigned k = 0; k < 9; k++)
        r_coef[k] <= coef_bus[k*COEF_W +: COEF_W];
    end
  end

  // S2..S4 datapath: products, per-row sums, total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 9; k++)
        r_prod[k] <= '0;
      for (int unsigned r = 0; r < 3; r++)
        r_rsum[r] <= '0;
      r_sum <= '0;
    end else begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          r_prod[3*r+c] <= PROD_W'(r_win[r][c]) * PROD_W'(r_coef[3*r+c]);
      for (int unsigned r = 0; r < 3; r++)
        r_rsum[r] <= SUM_W'(r_prod[3*r]) + SUM_W'(r_prod[3*r+1]) + SUM_W'(r_prod[3*r+2]);
      r_sum <= r_rsum[0] + r_rsum[1] + r_rsum[2];
    end
  end

  // Token flags riding alongside the datapath: window-valid and end-of-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_v1, r_v2, r_v3, r_v4} <= '0;
      {r_l1, r_l2, r_l3, r_l4} <= '0;
    end else begin
      r_v1 <= col_valid && (r_col_cnt >= COL_FIRST);
      r_l1 <= col_valid && w_last_col && w_last_row;
      r_v2 <= r_v1;
      r_l2 <= r_l1;
      r_v3 <= r_v2;
      r_l3 <= r_l2;
      r_v4 <= r_v3;
      r_l4 <= r_l3;
    end
  end

  // S5 combinational: round half-up, arithmetic shift, saturate, optional clamp at zero.
  always_comb begin
    w_rnd = EXT_W'(r_sum) + RND;
    w_shf = w_rnd >>> SHIFT;
    if (w_shf > SAT_MAX)
      w_sat = SAT_MAX[OUT_W-1:0];
    else if (w_shf < SAT_MIN)
      w_sat = SAT_MIN[OUT_W-1:0];
    else
      w_sat = w_shf[OUT_W-1:0];
`ifdef CONV_RELU_EN
    w_res = w_sat[OUT_W-1] ? '0 : w_sat;
`else
    w_res = w_sat;
`endif
  end

  // S5 output register; dout holds its last value between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (r_v4)
        dout <= w_res;
      dout_valid <= r_v4;
      frame_done <= r_v4 && r_l4;
    end
  end

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Testbench for conv3x3_window_mac: two instances (SHIFT=0 and SHIFT=2) share all inputs;
// a reference model pushes expected outputs at stimulus time, a negedge monitor pops them.
module tb_conv3x3_window_mac;

  localparam int COL_NUM = 8;
  localparam int ROW_NUM = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] row_top, row_mid, row_bot;
  logic        col_valid, coef_load;
  logic [71:0] coef_bus;
  logic [15:0] dout, dout_s;
  logic        dout_valid, dout_valid_s, frame_done, frame_done_s;

  always #5 clk = ~clk;

  conv3x3_window_mac #(.WIDTH(16), .COEF_W(8), .OUT_W(16), .SHIFT(0),
                       .COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM)) u_dut (
    .clk(clk), .rst_n(rst_n), .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
    .col_valid(col_valid), .coef_load(coef_load), .coef_bus(coef_bus),
    .dout(dout), .dout_valid(dout_valid), .frame_done(frame_done));

  conv3x3_window_mac #(.WIDTH(16), .COEF_W(8), .OUT_W(16), .SHIFT(2),
                       .COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
    .col_valid(col_valid), .coef_load(coef_load), .coef_bus(coef_bus),
    .dout(dout_s), .dout_valid(dout_valid_s), .frame_done(frame_done_s));

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e2;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t   q[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;
  int     n_out  = 0;
  int     n_fd   = 0;
  longint m_win [3][3];
  longint m_coef[9];
  int     m_col, m_row;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sat(input longint v);
    longint r;
    r = v;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef CONV_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  function automatic logic [71:0] all_coef(input int v);
    logic [71:0] b;
    for (int k = 0; k < 9; k++) b[k*8 +: 8] = 8'(v);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) m_win[r][c] = 0;
    for (int k = 0; k < 9; k++) m_coef[k] = 0;
    m_col = 0;
    m_row = 0;
    q.delete();
  endtask

  // One clock of stimulus; the model is updated to match what the DUT samples on the next edge.
  task automatic cycle_in(input logic v, input longint t, input longint m, input longint b,
                          input logic ld, input logic [71:0] bus);
    exp_t   e;
    longint s;
    @(posedge clk); #1;
    row_top = 16'(t); row_mid = 16'(m); row_bot = 16'(b);
    col_valid = v; coef_load = ld; coef_bus = bus;
    if (ld)
      for (int k = 0; k < 9; k++) m_coef[k] = longint'($signed(bus[k*8 +: 8]));
    if (v) begin
      for (int r = 0; r < 3; r++) begin
        m_win[r][0] = m_win[r][1];
        m_win[r][1] = m_win[r][2];
      end
      m_win[0][2] = t; m_win[1][2] = m; m_win[2][2] = b;
      if (m_col >= 2) begin
        s = 0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) s += m_win[r][c] * m_coef[3*r+c];
        e.e0   = 16'(sat(s));
        e.e2   = 16'(sat((s + 2) >>> 2));
        e.last = (m_col == COL_NUM-1) && (m_row == ROW_NUM-4);
        e.cyc  = cyc + 5;
        q.push_back(e);
      end
      if (m_col == COL_NUM-1) begin
        m_col = 0;
        m_row = (m_row == ROW_NUM-4) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic col(input longint t, input longint m, input longint b);
    cycle_in(1'b1, t, m, b, 1'b0, coef_bus);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_in(1'b0, 0, 0, 0, 1'b0, coef_bus);
  endtask

  task automatic load(input logic [71:0] bus);
    cycle_in(1'b0, 0, 0, 0, 1'b1, bus);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d outputs still pending, required 0", name, q.size());
    end
    q.delete();
  endtask

  // Scoreboard monitor: both instances must agree on timing; values and frame_done are popped.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      checks++;
      if (dout_valid !== dout_valid_s) begin
        errors++;
        $display("FAIL valid_pair: dout_valid=%b shifted dout_valid=%b, required equal", dout_valid, dout_valid_s);
      end
      if (dout_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stray_valid: dout_valid=1 at cycle %0d with no window expected", cyc);
        end else begin
          e = q.pop_front();
          n_out++;
          checks += 4;
          if (dout !== e.e0) begin
            errors++;
            $display("FAIL dout: got %0d required %0d (cycle %0d)", $signed(dout), $signed(e.e0), cyc);
          end
          if (dout_s !== e.e2) begin
            errors++;
            $display("FAIL dout_shift2: got %0d required %0d (cycle %0d)", $signed(dout_s), $signed(e.e2), cyc);
          end
          if (frame_done !== e.last || frame_done_s !== e.last) begin
            errors++;
            $display("FAIL frame_done: got %b/%b required %b (cycle %0d)", frame_done, frame_done_s, e.last, cyc);
          end
          if (cyc !== e.cyc) begin
            errors++;
            $display("FAIL latency: output at cycle %0d required cycle %0d", cyc, e.cyc);
          end
        end
      end else begin
        checks++;
        if (frame_done !== 1'b0 || frame_done_s !== 1'b0) begin
          errors++;
          $display("FAIL frame_done_idle: got %b/%b required 0 without dout_valid", frame_done, frame_done_s);
        end
      end
      if (frame_done === 1'b1) n_fd++;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    row_top = '0; row_mid = '0; row_bot = '0;
    col_valid = 1'b0; coef_load = 1'b0; coef_bus = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks += 3;
    if (dout !== 16'd0 || dout_s !== 16'd0) begin
      errors++; $display("FAIL reset_dout: got %0d/%0d required 0", dout, dout_s);
    end
    if (dout_valid !== 1'b0 || dout_valid_s !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b/%b required 0", dout_valid, dout_valid_s);
    end
    if (frame_done !== 1'b0 || frame_done_s !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done: got %b/%b required 0", frame_done, frame_done_s);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Full frame of constant pixels through all-ones kernel: 6 windows/row, 3 rows, frame_done on 18th.
  task automatic test_full_frame(input string name);
    int o0, f0;
    load(all_coef(1));
    o0 = n_out; f0 = n_fd;
    for (int i = 0; i < COL_NUM*(ROW_NUM-3); i++) col(10, 10, 10);
    idle(8);
    checks += 2;
    if (n_out - o0 != 18) begin
      errors++; $display("FAIL %s_count: got %0d windows required 18", name, n_out - o0);
    end
    if (n_fd - f0 != 1) begin
      errors++; $display("FAIL %s_frames: got %0d frame_done pulses required 1", name, n_fd - f0);
    end
    check_drained(name);
  endtask

  task automatic test_identity();
    logic [71:0] b;
    b = '0;
    b[4*8 +: 8] = 8'd1;
    load(b);
    for (int i = 0; i < COL_NUM; i++)
      col(longint'($urandom_range(65535)) - 32768, i, longint'($urandom_range(65535)) - 32768);
    idle(8);
    check_drained("identity");
  endtask

  task automatic test_saturation();
    load(all_coef(127));
    for (int i = 0; i < COL_NUM; i++) col(32767, 32767, 32767);
    for (int i = 0; i < COL_NUM; i++) col(-32768, -32768, -32768);
    idle(8);
    check_drained("saturation");
  endtask

  task automatic test_shift_round();
    load(all_coef(1));
    for (int i = 0; i < COL_NUM; i++) col(3, 3, 3);
    for (int i = 0; i < COL_NUM; i++) col(-3, -3, -3);
    idle(8);
    check_drained("shift_round");
  endtask

  // Load coincident with a column, then a load in an idle gap mid-row.
  task automatic test_coef_switch();
    load(all_coef(1));
    for (int i = 0; i < COL_NUM; i++) begin
      if (i == 4) cycle_in(1'b1, 10, 10, 10, 1'b1, all_coef(2));
      else        col(10, 10, 10);
    end
    for (int i = 0; i < COL_NUM; i++) begin
      if (i == 5) load(all_coef(1));
      col(10, 10, 10);
    end
    idle(8);
    check_drained("coef_switch");
  endtask

  task automatic test_gap_and_reset();
    int o0;
    load(all_coef(1));
    for (int i = 0; i < COL_NUM; i++) begin
      if (i == 4) idle(3);
      col(i + 1, 2*i, -i);
    end
    idle(8);
    check_drained("gap");
    for (int i = 0; i < 4; i++) col(7, 7, 7);
    @(posedge clk); #1;
    col_valid = 1'b0; coef_load = 1'b0;
    rst_n = 1'b0;
    model_reset();
    o0 = n_out;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 16'd0) begin
      errors++; $display("FAIL async_reset: dout_valid=%b dout=%0d required 0/0", dout_valid, dout);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);
    checks++;
    if (n_out != o0) begin
      errors++; $display("FAIL stale_after_reset: got %0d outputs required 0", n_out - o0);
    end
    test_full_frame("post_reset_frame");
  endtask

  initial begin
    test_reset();
    test_full_frame("full_frame");
    test_identity();
    test_saturation();
    test_shift_round();
    test_coef_switch();
    test_gap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
